register_block: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/register_block_read_port.sv | 46 ++++
 rtl/register_block.sv | 81 ++++++++
 tb/tb_register_block.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the dual-read, dual-write MIPS register file.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/register_block_read_port.sv
// One combinational read port: index mux, r0 override and, when REGFILE_WRITE_BYPASS_EN
// is defined, forwarding from the in-flight write ports.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic [DATA_W-1:0] registers [NUM_REGS],
    input  logic [ADDR_W-1:0] read_reg,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg1,
    input  logic [DATA_W-1:0] write_data1,
    input  logic              enable,
    input  logic [ADDR_W-1:0] write_reg2,
    input  logic [DATA_W-1:0] write_data2,
`endif
    output logic [DATA_W-1:0] read_data
);

    logic [DATA_W-1:0] array_data;

    assign array_data = (read_reg == ZERO_REG) ? '0 : registers[read_reg];

`ifdef REGFILE_WRITE_BYPASS_EN
    // Port 1 forwarding takes priority, mirroring the write-side conflict rule.
    always_comb begin
        read_data = array_data;
        if (rst) begin
            read_data = '0;
        end else if (read_reg != ZERO_REG) begin
            if (reg_write && (write_reg1 == read_reg)) begin
                read_data = write_data1;
            end else if (enable && (write_reg2 == read_reg)) begin
                read_data = write_data2;
            end
        end
    end
`else
    assign read_data = array_data;
`endif

endmodule

// File: rtl/register_block.sv
// 32x32 register file, two combinational reads, two falling-edge writes (port 1 wins conflicts).
// Optional read forwarding is enabled with REGFILE_WRITE_BYPASS_EN.
module register_block
#(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg1,
    input  logic [ADDR_W-1:0] write_reg2,
    input  logic [DATA_W-1:0] write_data1,
    input  logic [DATA_W-1:0] write_data2,
    input  logic              enable,
    input  logic              reg_write
);

    import regfile_pkg::*;

    logic [DATA_W-1:0] registers [NUM_REGS];

    logic [ADDR_W-1:0] read_addr [2];
    logic [DATA_W-1:0] read_val  [2];

    logic write1_ok;
    logic write2_ok;

    assign write1_ok = reg_write && (write_reg1 != ZERO_REG);
    assign write2_ok = enable && (write_reg2 != ZERO_REG) &&
                       !(reg_write && (write_reg1 == write_reg2));

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                registers[i] <= '0;
            end
        end else begin
            if (write2_ok) begin
                registers[write_reg2] <= write_data2;
            end
            if (write1_ok) begin
                registers[write_reg1] <= write_data1;
            end
        end
    end

    assign read_addr[0] = read_reg1;
    assign read_addr[1] = read_reg2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            regfile_read_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .NUM_REGS (NUM_REGS)
            ) u_read_port (
                .registers   (registers),
                .read_reg    (read_addr[gi]),
`ifdef REGFILE_WRITE_BYPASS_EN
                .rst         (rst),
                .reg_write   (reg_write),
                .write_reg1  (write_reg1),
                .write_data1 (write_data1),
                .enable      (enable),
                .write_reg2  (write_reg2),
                .write_data2 (write_data2),
`endif
                .read_data   (read_val[gi])
            );
        end
    endgenerate

    assign read_data1 = read_val[0];
    assign read_data2 = read_val[1];

endmodule

// File: tb/tb_register_block.sv
// Scoreboard bench for register_block: expected read values are queued from a bench-side model.
`timescale 1ns/100ps
module tb_register_block;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    reg_data_t read_data1, read_data2;
    reg_addr_t read_reg1 = '0, read_reg2 = '0;
    reg_addr_t write_reg1 = '0, write_reg2 = '0;
    reg_data_t write_data1 = '0, write_data2 = '0;
    logic      enable = 1'b0, reg_write = 1'b0;

    reg_data_t model [NUM_REGS];
    reg_data_t sb [$];
    reg_data_t exp_val;
    int        vectors = 0;
    int        miscompares = 0;

    register_block dut (
        .clk(clk), .rst(rst),
        .read_data1(read_data1), .read_data2(read_data2),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg1(write_reg1), .write_reg2(write_reg2),
        .write_data1(write_data1), .write_data2(write_data2),
        .enable(enable), .reg_write(reg_write)
    );

    always #5 clk = ~clk;

    // Drive one write transaction after a rising edge, commit at the falling edge, update model.
    task automatic write_cycle(input logic we1, input reg_addr_t a1, input reg_data_t d1,
                               input logic we2, input reg_addr_t a2, input reg_data_t d2);
        @(posedge clk); #1;
        reg_write = we1; write_reg1 = a1; write_data1 = d1;
        enable = we2; write_reg2 = a2; write_data2 = d2;
        @(negedge clk); #1;
        if (we2 && a2 != 0 && !(we1 && a1 == a2)) model[a2] = d2;
        if (we1 && a1 != 0) model[a1] = d1;
        reg_write = 1'b0; enable = 1'b0;
        write_data1 = '0; write_data2 = '0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        read_reg1 = 5'd1; read_reg2 = 5'd31;
        sb.push_back(32'h0); sb.push_back(32'h0);
        #1;
        vectors++; exp_val = sb.pop_front();
        if (read_data1 !== exp_val) begin miscompares++; $display("FAIL reset_rd1 got=%h exp=%h", read_data1, exp_val); end
        vectors++; exp_val = sb.pop_front();
        if (read_data2 !== exp_val) begin miscompares++; $display("FAIL reset_rd2 got=%h exp=%h", read_data2, exp_val); end
        $display("reset: rd1=%h rd2=%h", read_data1, read_data2);
        rst = 1'b0;
    endtask

    task automatic test_preload;
        for (int i = 1; i < NUM_REGS; i += 2) begin
            write_cycle(1'b1, reg_addr_t'(i), 32'hA5000000 ^ (i * 32'h00010203),
                        1'b1, reg_addr_t'((i + 1) % NUM_REGS), 32'h5A000000 ^ ((i + 1) * 32'h00030201));
            $display("preload: r%0d r%0d", i, (i + 1) % NUM_REGS);
        end
    endtask

    task automatic test_port1;
        write_cycle(1'b1, 5'd10, 32'hFFFFFFFF, 1'b0, 5'd11, 32'h0);
        for (int k = 0; k < 2; k++) begin
            read_reg1 = (k == 0) ? 5'd10 : 5'd31;
            read_reg2 = (k == 0) ? 5'd11 : 5'd1;
            sb.push_back(model[read_reg1]); sb.push_back(model[read_reg2]);
            #1;
            vectors++; exp_val = sb.pop_front();
            if (read_data1 !== exp_val) begin miscompares++; $display("FAIL port1_rd1 r%0d got=%h exp=%h", read_reg1, read_data1, exp_val); end
            vectors++; exp_val = sb.pop_front();
            if (read_data2 !== exp_val) begin miscompares++; $display("FAIL port1_rd2 r%0d got=%h exp=%h", read_reg2, read_data2, exp_val); end
            $display("port1: r%0d=%h r%0d=%h", read_reg1, read_data1, read_reg2, read_data2);
        end
    endtask

    task automatic test_both;
        write_cycle(1'b1, 5'd11, 32'h01C08A85, 1'b1, 5'd12, 32'hF0100400);
        for (int k = 0; k < 2; k++) begin
            read_reg1 = (k == 0) ? 5'd11 : 5'd2;
            read_reg2 = (k == 0) ? 5'd12 : 5'd3;
            sb.push_back(model[read_reg1]); sb.push_back(model[read_reg2]);
            #1;
            vectors++; exp_val = sb.pop_front();
            if (read_data1 !== exp_val) begin miscompares++; $display("FAIL both_rd1 r%0d got=%h exp=%h", read_reg1, read_data1, exp_val); end
            vectors++; exp_val = sb.pop_front();
            if (read_data2 !== exp_val) begin miscompares++; $display("FAIL both_rd2 r%0d got=%h exp=%h", read_reg2, read_data2, exp_val); end
            $display("both: r%0d=%h r%0d=%h", read_reg1, read_data1, read_reg2, read_data2);
        end
    endtask

    task automatic test_port2;
        write_cycle(1'b0, 5'd13, 32'd100, 1'b1, 5'd14, 32'h00333014);
        read_reg1 = 5'd13; read_reg2 = 5'd14;
        sb.push_back(model[13]); sb.push_back(32'h00333014);
        #1;
        vectors++; exp_val = sb.pop_front();
        if (read_data1 !== exp_val) begin miscompares++; $display("FAIL port2_r13 got=%h exp=%h", read_data1, exp_val); end
        vectors++; exp_val = sb.pop_front();
        if (read_data2 !== exp_val) begin miscompares++; $display("FAIL port2_r14 got=%h exp=%h", read_data2, exp_val); end
        $display("port2: r13=%h r14=%h", read_data1, read_data2);
    endtask

    task automatic test_no_write_dump;
        write_cycle(1'b0, 5'd15, 32'hDEADBEEF, 1'b0, 5'd16, 32'hCAFEF00D);
        for (int i = 0; i < NUM_REGS; i += 2) begin
            read_reg1 = reg_addr_t'(i); read_reg2 = reg_addr_t'(i + 1);
            sb.push_back(model[i]); sb.push_back(model[i + 1]);
            #1;
            vectors++; exp_val = sb.pop_front();
            if (read_data1 !== exp_val) begin miscompares++; $display("FAIL dump r%0d got=%h exp=%h", i, read_data1, exp_val); end
            vectors++; exp_val = sb.pop_front();
            if (read_data2 !== exp_val) begin miscompares++; $display("FAIL dump r%0d got=%h exp=%h", i + 1, read_data2, exp_val); end
            $display("dump: r%0d=%h r%0d=%h", i, read_data1, i + 1, read_data2);
        end
    endtask

    task automatic test_zero_and_conflict;
        write_cycle(1'b1, 5'd0, 32'h11111111, 1'b1, 5'd0, 32'h22222222);
        write_cycle(1'b1, 5'd5, 32'hAAAA0001, 1'b1, 5'd5, 32'hBBBB0002);
        read_reg1 = 5'd0; read_reg2 = 5'd5;
        sb.push_back(32'h0); sb.push_back(32'hAAAA0001);
        #1;
        vectors++; exp_val = sb.pop_front();
        if (read_data1 !== exp_val) begin miscompares++; $display("FAIL zero_reg got=%h exp=%h", read_data1, exp_val); end
        vectors++; exp_val = sb.pop_front();
        if (read_data2 !== exp_val) begin miscompares++; $display("FAIL conflict_r5 got=%h exp=%h", read_data2, exp_val); end
        $display("edge: r0=%h r5=%h", read_data1, read_data2);
    endtask

    task automatic test_read_during_write;
        reg_data_t old7;
        old7 = model[7];
        @(posedge clk); #1;
        reg_write = 1'b1; write_reg1 = 5'd7; write_data1 = 32'h00001234;
        enable = 1'b1; write_reg2 = 5'd8; write_data2 = 32'h00005678;
        read_reg1 = 5'd7; read_reg2 = 5'd8;
`ifdef REGFILE_WRITE_BYPASS_EN
        sb.push_back(32'h00001234); sb.push_back(32'h00005678);
`else
        sb.push_back(old7); sb.push_back(model[8]);
`endif
        #1;
        vectors++; exp_val = sb.pop_front();
        if (read_data1 !== exp_val) begin miscompares++; $display("FAIL rdw_pre_rd1 got=%h exp=%h", read_data1, exp_val); end
        vectors++; exp_val = sb.pop_front();
        if (read_data2 !== exp_val) begin miscompares++; $display("FAIL rdw_pre_rd2 got=%h exp=%h", read_data2, exp_val); end
        $display("rdw pre-edge: r7=%h r8=%h", read_data1, read_data2);
        @(negedge clk); #1;
        model[7] = 32'h00001234; model[8] = 32'h00005678;
        reg_write = 1'b0; enable = 1'b0;
        sb.push_back(model[7]); sb.push_back(model[8]);
        #1;
        vectors++; exp_val = sb.pop_front();
        if (read_data1 !== exp_val) begin miscompares++; $display("FAIL rdw_post_rd1 got=%h exp=%h", read_data1, exp_val); end
        vectors++; exp_val = sb.pop_front();
        if (read_data2 !== exp_val) begin miscompares++; $display("FAIL rdw_post_rd2 got=%h exp=%h", read_data2, exp_val); end
        $display("rdw post-edge: r7=%h r8=%h", read_data1, read_data2);
    endtask

    task automatic test_rst_midcycle;
        @(posedge clk); #2;
        read_reg1 = 5'd5; read_reg2 = 5'd10;
        rst = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        sb.push_back(32'h0); sb.push_back(32'h0);
        #1;
        vectors++; exp_val = sb.pop_front();
        if (read_data1 !== exp_val) begin miscompares++; $display("FAIL rst_mid_rd1 got=%h exp=%h", read_data1, exp_val); end
        vectors++; exp_val = sb.pop_front();
        if (read_data2 !== exp_val) begin miscompares++; $display("FAIL rst_mid_rd2 got=%h exp=%h", read_data2, exp_val); end
        $display("rst mid-cycle: r5=%h r10=%h", read_data1, read_data2);
        // Writes presented while reset is held must be ignored.
        reg_write = 1'b1; write_reg1 = 5'd9; write_data1 = 32'h99999999;
        @(negedge clk); #1;
        reg_write = 1'b0;
        read_reg1 = 5'd9; read_reg2 = 5'd31;
        sb.push_back(32'h0); sb.push_back(32'h0);
        #1;
        vectors++; exp_val = sb.pop_front();
        if (read_data1 !== exp_val) begin miscompares++; $display("FAIL rst_hold_r9 got=%h exp=%h", read_data1, exp_val); end
        vectors++; exp_val = sb.pop_front();
        if (read_data2 !== exp_val) begin miscompares++; $display("FAIL rst_hold_r31 got=%h exp=%h", read_data2, exp_val); end
        $display("rst held: r9=%h r31=%h", read_data1, read_data2);
        rst = 1'b0;
        write_cycle(1'b1, 5'd9, 32'h0BADF00D, 1'b0, 5'd0, 32'h0);
        sb.push_back(model[9]);
        #1;
        vectors++; exp_val = sb.pop_front();
        if (read_data1 !== exp_val) begin miscompares++; $display("FAIL post_rst_r9 got=%h exp=%h", read_data1, exp_val); end
        $display("post reset write: r9=%h", read_data1);
    endtask

    initial begin
        test_reset;
        test_preload;
        test_port1;
        test_both;
        test_port2;
        test_no_write_dump;
        test_zero_and_conflict;
        test_read_during_write;
        test_rst_midcycle;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
